pb_conditioner: RTL and testbench
=================================

# pb_conditioner

Pushbutton front end for the KROS board design: synchronises, debounces and edge-detects the raw KEY inputs, giving clean levels and single-cycle press/release strobes. Sits directly upstream of `throttle` (`pb_freq_up`/`pb_freq_dn`) and `sequencer` (`pb_seq_up`/`pb_seq_dn`), replacing raw-key wiring into those blocks. All logic runs on `CLK_50`. The block contains no combinational path from input to output.

## Interface
- `NUM_PB`, 4: number of button channels.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles needed to accept a change (20 ms at 50 MHz); must be ≥1.
- `ACTIVE_LOW`, 1: 1 means raw input 0 is pressed (DE-series KEYs); 0 means raw input 1 is pressed.
- `HOLD_CYCLES`, 25000000: hold time before the first auto-repeat strobe; used only with `PB_AUTOREPEAT_EN`.
- `REPEAT_CYCLES`, 5000000: auto-repeat period; used only with `PB_AUTOREPEAT_EN`.
- `CLK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `pb_raw`  in  NUM_PB  asynchronous raw button pins.
- `pb_level`  out  NUM_PB  debounced state, 1 = pressed.
- `pb_press`  out  NUM_PB  one-cycle strobe on accepted press (and on auto-repeat).
- `pb_release`  out  NUM_PB  one-cycle strobe on accepted release.

## Operation
- Channels are fully independent; each holds a 2-flop synchroniser, a debounce counter, a stable-state register `st`, and, if configured, a hold counter.
- Polarity: synchroniser output `s` is inverted when `ACTIVE_LOW`=1, so `s`=1 always means pressed.
- Debounce: if `s == st`, the counter clears to 0. If `s != st`, the counter increments. When the counter is at `DEBOUNCE_CYCLES-1` and `s != st`:
  - `st` takes the value of `s`;
  - the counter clears to 0;
  - `pb_press` (0→1) or `pb_release` (1→0) pulses for exactly that one cycle.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`; the counter never wraps.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles restarts the count and produces no output change.
- `pb_level` equals `st`, registered.
- Simultaneous events on different channels all strobe in the same cycle. There is no arbitration.
- Reset (asynchronous, any time, including mid-count):
  - synchroniser flops are loaded with the released level (1 if `ACTIVE_LOW`, else 0);
  - `st`, all counters, `pb_level`, `pb_press` and `pb_release` go to 0.
- A button held through reset deassertion is treated as a new press and strobes after the normal latency.

## Timing
- Let edge k be the first `CLK_50` rising edge that samples a new raw value, with the value held stable afterwards.
- `pb_level` and the strobe update at edge k+DEBOUNCE_CYCLES+1, so they are visible after that edge.
- Strobe width is exactly 1 cycle. Minimum spacing between a press and the following release is `DEBOUNCE_CYCLES` cycles.
- With `DEBOUNCE_CYCLES`=1, the output follows the synchroniser with 1 extra cycle (total 2 edges).
- After reset deasserts, the first edge that can sample is k; the same formula applies.

## Configuration
- `PB_AUTOREPEAT_EN` defined:
  - while `st`=1, the hold counter counts cycles since the last strobe;
  - the first repeat `pb_press` fires `HOLD_CYCLES` cycles after the accepted-press strobe;
  - subsequent repeats fire every `REPEAT_CYCLES` cycles;
  - the hold counter clears on release or reset, and on the release cycle `pb_release` pulses with no repeat;
  - the hold counter saturates and never wraps.
- `PB_AUTOREPEAT_EN` undefined: no hold counters are built, and `pb_press` fires exactly once per accepted press.
- Behaviour of `pb_level` and `pb_release` is identical in both builds.

## Test plan
All scenarios use `NUM_PB`=4, `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW`=1.
- Reset with `pb_raw`=4'b1111: all outputs are 0. Drive `pb_raw[0]`=0 before edge k → `pb_level[0]`=1 and a single `pb_press[0]` pulse at edge k+5, and nothing on other channels.
- Bounce `pb_raw[1]` low for 3 cycles, high for 1, then low steady → no strobe during the bounce, and `pb_press[1]` occurs 5 edges after the final low is first sampled.
- Press then release channels 2 and 3 on the same edge → simultaneous `pb_press`=4'b1100, then later `pb_release`=4'b1100 in the same cycle.
- Hold `pb_raw[0]` low, assert `reset` mid-count (counter=2), and deassert after 3 cycles → outputs are 0 during reset, and `pb_press[0]` fires 5 edges after the first post-reset sampling edge.
- With `PB_AUTOREPEAT_EN`, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=3, hold for 30 cycles → press strobes at t0, t0+10, t0+13, t0+16, and so on. On release there is one `pb_release` strobe and no further `pb_press`. Without the macro, the same stimulus gives exactly one `pb_press`.

Source files
------------

// File: rtl/pb_conditioner.sv
// Pushbutton front end: per-channel 2-flop synchroniser, debounce and press/release strobes.
// Optional auto-repeat of pb_press while held is built only when PB_AUTOREPEAT_EN is defined.
module pb_conditioner #(
  parameter int NUM_PB          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_press,
  output logic [NUM_PB-1:0] pb_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_PB-1:0] IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("pb_conditioner: cycle-count parameters must be >= 1");
  end

  logic [NUM_PB-1:0] sync1;
  logic [NUM_PB-1:0] sync2;
  logic [NUM_PB-1:0] s;
  logic [NUM_PB-1:0] st;
  logic [CW-1:0]     cnt [NUM_PB];

`ifdef PB_AUTOREPEAT_EN
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  logic [HW-1:0]     hold [NUM_PB];
  logic [NUM_PB-1:0] rep;
`endif

  // s = 1 always means pressed, whatever the pin polarity
  assign s        = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign pb_level = st;

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      sync1      <= IDLE;
      sync2      <= IDLE;
      st         <= '0;
      pb_press   <= '0;
      pb_release <= '0;
      for (int unsigned i = 0; i < NUM_PB; i++) begin
        cnt[i] <= '0;
`ifdef PB_AUTOREPEAT_EN
        hold[i] <= '0;
        rep[i]  <= 1'b0;
`endif
      end
    end else begin
      sync1      <= pb_raw;
      sync2      <= sync1;
      pb_press   <= '0;
      pb_release <= '0;
      for (int unsigned i = 0; i < NUM_PB; i++) begin
        if (s[i] != st[i] && cnt[i] == CNT_LAST) begin
          st[i]         <= s[i];
          cnt[i]        <= '0;
          pb_press[i]   <= s[i];
          pb_release[i] <= ~s[i];
`ifdef PB_AUTOREPEAT_EN
          hold[i] <= '0;
          rep[i]  <= 1'b0;
`endif
        end else begin
          if (s[i] == st[i]) begin
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
`ifdef PB_AUTOREPEAT_EN
          // hold counts edges since the last press strobe; first gap HOLD, then REPEAT
          if (st[i]) begin
            if ((!rep[i] && hold[i] == HOLD_LAST) || (rep[i] && hold[i] == REP_LAST)) begin
              pb_press[i] <= 1'b1;
              hold[i]     <= '0;
              rep[i]      <= 1'b1;
            end else if (hold[i] != '1) begin
              hold[i] <= hold[i] + 1'b1;
            end
          end else begin
            hold[i] <= '0;
            rep[i]  <= 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner: expected strobes are queued with their due cycle and checked every cycle.
module tb_pb_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned LAT = DEB + 2;  // drive just after edge c -> output after edge c+1+DEB+1

  logic       CLK_50;
  logic       reset;
  logic [3:0] pb_raw;
  logic [3:0] pb_level;
  logic [3:0] pb_press;
  logic [3:0] pb_release;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
  } ev_t;

  ev_t         q[$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  exp_level = '0;

  pb_conditioner #(
    .NUM_PB(4),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW(1),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3)
  ) dut (
    .CLK_50(CLK_50),
    .reset(reset),
    .pb_raw(pb_raw),
    .pb_level(pb_level),
    .pb_press(pb_press),
    .pb_release(pb_release)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  always @(posedge CLK_50) cyc++;

  task automatic expect_at(input int unsigned at, input logic [3:0] p, input logic [3:0] r);
    ev_t e;
    int  idx;
    e.cyc = at;
    e.press = p;
    e.rel = r;
    idx = 0;
    while (idx < q.size() && q[idx].cyc <= at) idx++;
    q.insert(idx, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK_50);
    #2;
  endtask

  // Checker: every cycle, away from the active edge
  always @(negedge CLK_50) begin
    logic [3:0] exp_p;
    logic [3:0] exp_r;
    exp_p = '0;
    exp_r = '0;
    if (reset) begin
      exp_level = '0;
    end else begin
      while (q.size() > 0 && q[0].cyc == cyc) begin
        exp_p = exp_p | q[0].press;
        exp_r = exp_r | q[0].rel;
        void'(q.pop_front());
      end
      exp_level = (exp_level | exp_p) & ~exp_r;
    end
    total++;
    assert (pb_press === exp_p) else begin
      bad++;
      $error("FAIL press cyc=%0d observed=%b expected=%b", cyc, pb_press, exp_p);
    end
    total++;
    assert (pb_release === exp_r) else begin
      bad++;
      $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, pb_release, exp_r);
    end
    total++;
    assert (pb_level === exp_level) else begin
      bad++;
      $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, pb_level, exp_level);
    end
  end

  initial begin
    int unsigned t0;
    reset  = 1'b1;
    pb_raw = 4'b1111;
    step(3);
    reset = 1'b0;
    step(3);

    // single press on channel 0
    pb_raw[0] = 1'b0;
    expect_at(cyc + LAT, 4'b0001, 4'b0000);
    step(10);

    // bounce on channel 1: 3 low, 1 high, then low steady
    pb_raw[1] = 1'b0;
    step(3);
    pb_raw[1] = 1'b1;
    step(1);
    pb_raw[1] = 1'b0;
    expect_at(cyc + LAT, 4'b0010, 4'b0000);
    step(10);

    // simultaneous press and release on channels 2 and 3
    pb_raw[3:2] = 2'b00;
    expect_at(cyc + LAT, 4'b1100, 4'b0000);
    step(10);
    pb_raw[3:2] = 2'b11;
    expect_at(cyc + LAT, 4'b0000, 4'b1100);
    step(10);

    // release channels 0 and 1 together
    pb_raw[1:0] = 2'b11;
    expect_at(cyc + LAT, 4'b0000, 4'b0011);
    step(10);

    // reset mid-count (counter at 2), held for 3 cycles
    pb_raw[0] = 1'b0;
    step(4);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    expect_at(cyc + LAT, 4'b0001, 4'b0000);
    step(10);

    // long hold: fresh press held 30 cycles, then release
    pb_raw[0] = 1'b1;
    expect_at(cyc + LAT, 4'b0000, 4'b0001);
    step(10);
    pb_raw[0] = 1'b0;
    t0 = cyc + LAT;
    expect_at(t0, 4'b0001, 4'b0000);
`ifdef PB_AUTOREPEAT_EN
    for (int unsigned t = t0 + 10; t < t0 + 30; t += 3) begin
      expect_at(t, 4'b0001, 4'b0000);
    end
`endif
    step(30);
    pb_raw[0] = 1'b1;
    expect_at(cyc + LAT, 4'b0000, 4'b0001);
    step(LAT + 10);

    total++;
    assert (q.size() === 0) else begin
      bad++;
      $error("FAIL drained observed=%0d expected=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
